// File: rtl/embcpu_nios2_qsys_0_oci_dct_packer_if.sv
// Handshake and status bundle between the branch-direction code source,
// the packer and the downstream trace FIFO.
interface embcpu_nios2_qsys_0_oci_dct_packer_if;
  logic        trc_on;
  logic        dct_in_valid;
  logic [1:0]  dct_in_code;
  logic        flush;
  logic        overflow_clr;
  logic        frame_ready;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  modport master (
    output trc_on, dct_in_valid, dct_in_code, flush, overflow_clr, frame_ready,
    input  frame_valid, frame_data, dct_buffer, dct_count, overflow
  );

  modport slave (
    input  trc_on, dct_in_valid, dct_in_code, flush, overflow_clr, frame_ready,
    output frame_valid, frame_data, dct_buffer, dct_count, overflow
  );
endinterface

// File: rtl/embcpu_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit branch-direction codes into 36-bit trace frames
// {2'b10, count, buffer}. Up to 15 codes per frame; a flush emits a partial
// frame. One output frame register with valid/ready handshake; codes that
// arrive while both the accumulator and the output slot are full are dropped
// and recorded in a sticky overflow flag.
module embcpu_nios2_qsys_0_oci_dct_packer (
  input  logic clk,
  input  logic reset,
  embcpu_nios2_qsys_0_oci_dct_packer_if.slave bus
);

  // Shift a new code in at the LSB end; oldest code drifts upward.
  function automatic logic [29:0] shift_in(input logic [29:0] b, input logic [1:0] c);
    return {b[27:0], c};
  endfunction

  // Registered state
  logic [29:0] buf_p1;
  logic [3:0]  cnt_p1;
  logic        flush_pend_p1;
  logic        vld_p1;
  logic [35:0] frame_p1;
  logic        overflow_p1;

  // Combinational view of this cycle
  logic        slot_free;
  logic        code_in;
  logic        full;
  logic        flush_pend_p0;
  logic [29:0] buf_p0;
  logic [3:0]  cnt_p0;
  logic        emit;
  logic        drop;
  logic [29:0] buf_nxt;
  logic [3:0]  cnt_nxt;
  logic        flush_pend_nxt;

  // Stage p0: append the offered code (acc'), decide emit/drop, next accumulator.
  always_comb begin
    slot_free     = !vld_p1 || bus.frame_ready;
    code_in       = bus.trc_on && bus.dct_in_valid;
    full          = (cnt_p1 == 4'd15);
    flush_pend_p0 = flush_pend_p1 || bus.flush;

    buf_p0 = buf_p1;
    cnt_p0 = cnt_p1;
    if (code_in && !full) begin
      buf_p0 = shift_in(buf_p1, bus.dct_in_code);
      cnt_p0 = cnt_p1 + 4'd1;
    end

    emit = slot_free && ((cnt_p0 == 4'd15) || (flush_pend_p0 && (cnt_p0 != 4'd0)));
    drop = code_in && full && !slot_free;

    buf_nxt = buf_p0;
    cnt_nxt = cnt_p0;
    if (emit) begin
      buf_nxt = '0;
      cnt_nxt = '0;
      // A full accumulator leaves as-is; the incoming code starts the next frame.
      if (code_in && full) begin
        buf_nxt = {28'd0, bus.dct_in_code};
        cnt_nxt = 4'd1;
      end
    end

    // An empty flush is simply consumed; otherwise it waits for a free slot.
    flush_pend_nxt = emit ? 1'b0 : (flush_pend_p0 && (cnt_p0 != 4'd0));
  end

  // Stage p1: accumulator, output frame slot and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_p1        <= '0;
      cnt_p1        <= '0;
      flush_pend_p1 <= 1'b0;
      vld_p1        <= 1'b0;
      frame_p1      <= '0;
      overflow_p1   <= 1'b0;
    end else begin
      buf_p1        <= buf_nxt;
      cnt_p1        <= cnt_nxt;
      flush_pend_p1 <= flush_pend_nxt;
      if (emit) begin
        vld_p1   <= 1'b1;
        frame_p1 <= {2'b10, cnt_p0, buf_p0};
      end else if (bus.frame_ready) begin
        vld_p1 <= 1'b0;
      end
      if (drop) begin
        overflow_p1 <= 1'b1;
      end else if (bus.overflow_clr) begin
        overflow_p1 <= 1'b0;
      end
    end
  end

  assign bus.frame_valid = vld_p1;
  assign bus.frame_data  = frame_p1;
  assign bus.dct_buffer  = buf_p1;
  assign bus.dct_count   = cnt_p1;
  assign bus.overflow    = overflow_p1;

endmodule
